// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : video_timing_gen
//  Brief    : Raster timing generator producing VDE, H/V sync, pixel
//             coordinates and line/frame start pulses for the TMDS encoders.
//  Revision : 1.0 - initial release
// ============================================================================
module video_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic H_POL    = 1'b0,
  parameter logic V_POL    = 1'b0
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        EN,
  output logic        VDE,
  output logic        HSYNC,
  output logic        VSYNC,
  output logic [1:0]  CONTROL,
  output logic [11:0] PIX_X,
  output logic [11:0] PIX_Y,
  output logic        LINE_START,
  output logic        FRAME_START
);

  localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Region bounds are 13 bits wide so a 4096 total cannot alias to zero.
  localparam logic [12:0] c_H_ACT_END  = 13'(H_ACTIVE);
  localparam logic [12:0] c_H_SYNC_BEG = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] c_H_SYNC_END = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] c_V_ACT_END  = 13'(V_ACTIVE);
  localparam logic [12:0] c_V_SYNC_BEG = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] c_V_SYNC_END = 13'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] c_H_LAST     = 12'(c_H_TOTAL - 1);
  localparam logic [11:0] c_V_LAST     = 12'(c_V_TOTAL - 1);

  logic [11:0] r_hcount;
  logic [11:0] r_vcount;
  logic        r_vde;
  logic        r_hsync;
  logic        r_vsync;
  logic [11:0] r_pix_x;
  logic [11:0] r_pix_y;
  logic        r_line_start;
  logic        r_frame_start;

  logic        w_h_wrap;
  logic        w_v_wrap;
  logic [11:0] w_h_next;
  logic [11:0] w_v_next;
  logic        w_h_act;
  logic        w_v_act;
  logic        w_h_in_sync;
  logic        w_v_in_sync;
  logic        w_hsync_lvl;
  logic        w_vsync_lvl;

  always_comb begin
    w_h_wrap    = (r_hcount == c_H_LAST);
    w_v_wrap    = (r_vcount == c_V_LAST);
    w_h_next    = w_h_wrap ? 12'd0 : r_hcount + 12'd1;
    w_v_next    = r_vcount;
    if (w_h_wrap) begin
      w_v_next = w_v_wrap ? 12'd0 : r_vcount + 12'd1;
    end
    w_h_act     = ({1'b0, r_hcount} < c_H_ACT_END);
    w_v_act     = ({1'b0, r_vcount} < c_V_ACT_END);
    w_h_in_sync = ({1'b0, r_hcount} >= c_H_SYNC_BEG) && ({1'b0, r_hcount} < c_H_SYNC_END);
    w_v_in_sync = ({1'b0, r_vcount} >= c_V_SYNC_BEG) && ({1'b0, r_vcount} < c_V_SYNC_END);
    w_hsync_lvl = w_h_in_sync ? H_POL : ~H_POL;
    w_vsync_lvl = w_v_in_sync ? V_POL : ~V_POL;
  end

  // EN low behaves exactly like reset so re-enable always starts at (0,0).
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_hcount      <= 12'd0;
      r_vcount      <= 12'd0;
      r_vde         <= 1'b0;
      r_hsync       <= ~H_POL;
      r_vsync       <= ~V_POL;
      r_pix_x       <= 12'd0;
      r_pix_y       <= 12'd0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (!EN) begin
      r_hcount      <= 12'd0;
      r_vcount      <= 12'd0;
      r_vde         <= 1'b0;
      r_hsync       <= ~H_POL;
      r_vsync       <= ~V_POL;
      r_pix_x       <= 12'd0;
      r_pix_y       <= 12'd0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_hcount      <= w_h_next;
      r_vcount      <= w_v_next;
      r_vde         <= w_h_act && w_v_act;
      r_hsync       <= w_hsync_lvl;
      r_vsync       <= w_vsync_lvl;
      r_pix_x       <= r_hcount;
      r_pix_y       <= r_vcount;
      r_line_start  <= (r_hcount == 12'd0);
      r_frame_start <= (r_hcount == 12'd0) && (r_vcount == 12'd0);
    end
  end

  assign VDE         = r_vde;
  assign HSYNC       = r_hsync;
  assign VSYNC       = r_vsync;
  assign CONTROL     = {r_vsync, r_hsync};
  assign PIX_X       = r_pix_x;
  assign PIX_Y       = r_pix_y;
  assign LINE_START  = r_line_start;
  assign FRAME_START = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_video_timing_gen
//  Brief    : Self-checking bench for video_timing_gen (640x480, a tiny
//             active-high raster, and 1280x720 active-high).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_video_timing_gen;

  logic CLK;
  logic RSTN;
  logic en0, en1, en2;

  logic        vde0, hs0, vs0, ls0, fs0;
  logic [1:0]  ctl0;
  logic [11:0] px0, py0;
  logic        vde1, hs1, vs1, ls1, fs1;
  logic [1:0]  ctl1;
  logic [11:0] px1, py1;
  logic        vde2, hs2, vs2, ls2, fs2;
  logic [1:0]  ctl2;
  logic [11:0] px2, py2;

  logic [30:0] o0, o1, o2;
  assign o0 = {vde0, hs0, vs0, ctl0, px0, py0, ls0, fs0};
  assign o1 = {vde1, hs1, vs1, ctl1, px1, py1, ls1, fs1};
  assign o2 = {vde2, hs2, vs2, ctl2, px2, py2, ls2, fs2};

  video_timing_gen dut0 (
    .CLK(CLK), .RSTN(RSTN), .EN(en0), .VDE(vde0), .HSYNC(hs0), .VSYNC(vs0),
    .CONTROL(ctl0), .PIX_X(px0), .PIX_Y(py0), .LINE_START(ls0), .FRAME_START(fs0)
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .H_POL(1'b1), .V_POL(1'b1)
  ) dut1 (
    .CLK(CLK), .RSTN(RSTN), .EN(en1), .VDE(vde1), .HSYNC(hs1), .VSYNC(vs1),
    .CONTROL(ctl1), .PIX_X(px1), .PIX_Y(py1), .LINE_START(ls1), .FRAME_START(fs1)
  );

  video_timing_gen #(
    .H_ACTIVE(1280), .H_FP(110), .H_SYNC(40), .H_BP(220),
    .V_ACTIVE(720), .V_FP(5), .V_SYNC(5), .V_BP(20),
    .H_POL(1'b1), .V_POL(1'b1)
  ) dut2 (
    .CLK(CLK), .RSTN(RSTN), .EN(en2), .VDE(vde2), .HSYNC(hs2), .VSYNC(vs2),
    .CONTROL(ctl2), .PIX_X(px2), .PIX_Y(py2), .LINE_START(ls2), .FRAME_START(fs2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected registered outputs for counter position (h,v) and sampled EN.
  function automatic logic [30:0] mdl(input int h, input int v, input bit en,
                                      input int ha, input int hf, input int hw,
                                      input int va, input int vf, input int vw,
                                      input bit hp, input bit vp);
    logic vde, hs, vs;
    if (!en) return {1'b0, ~hp, ~vp, ~vp, ~hp, 24'd0, 2'b00};
    vde = (h < ha) && (v < va);
    hs  = (h >= ha + hf && h < ha + hf + hw) ? hp : ~hp;
    vs  = (v >= va + vf && v < va + vf + vw) ? vp : ~vp;
    return {vde, hs, vs, vs, hs, 12'(h), 12'(v), (h == 0), (h == 0 && v == 0)};
  endfunction

  task automatic adv(inout int h, inout int v, input int ht, input int vt);
    h = h + 1;
    if (h == ht) begin
      h = 0;
      v = (v + 1 == vt) ? 0 : v + 1;
    end
  endtask

  logic [30:0] q0[$], q1[$], q2[$];
  int h0 = 0, v0 = 0, h1 = 0, v1 = 0, h2 = 0, v2 = 0;

  // Scoreboard producer: predicts the outputs each clock edge will register.
  initial forever begin
    @(posedge CLK);
    if (!RSTN) begin
      q0.push_back(mdl(0, 0, 1'b0, 640, 16, 96, 480, 10, 2, 1'b0, 1'b0));
      q1.push_back(mdl(0, 0, 1'b0, 8, 2, 3, 4, 1, 2, 1'b1, 1'b1));
      q2.push_back(mdl(0, 0, 1'b0, 1280, 110, 40, 720, 5, 5, 1'b1, 1'b1));
      h0 = 0; v0 = 0; h1 = 0; v1 = 0; h2 = 0; v2 = 0;
    end else begin
      q0.push_back(mdl(h0, v0, en0, 640, 16, 96, 480, 10, 2, 1'b0, 1'b0));
      q1.push_back(mdl(h1, v1, en1, 8, 2, 3, 4, 1, 2, 1'b1, 1'b1));
      q2.push_back(mdl(h2, v2, en2, 1280, 110, 40, 720, 5, 5, 1'b1, 1'b1));
      if (en0) adv(h0, v0, 800, 525);    else begin h0 = 0; v0 = 0; end
      if (en1) adv(h1, v1, 16, 9);       else begin h1 = 0; v1 = 0; end
      if (en2) adv(h2, v2, 1650, 750);   else begin h2 = 0; v2 = 0; end
    end
  end

  // Scoreboard consumer: compares on the falling edge, away from updates.
  initial forever begin
    @(negedge CLK);
    if (q0.size() > 0) chk("sb0", 32'(o0), 32'(q0.pop_front()));
    if (q1.size() > 0) chk("sb1", 32'(o1), 32'(q1.pop_front()));
    if (q2.size() > 0) chk("sb2", 32'(o2), 32'(q2.pop_front()));
  end

  initial begin
    int vcnt, hcnt, lcnt, first, last, fcnt, vscnt, vmin, vmax, badvde;
    int lpx, lpy;
    bit found;

    RSTN = 1'b0;
    en0 = 1'b1; en1 = 1'b1; en2 = 1'b1;
    repeat (3) @(negedge CLK);

    // Held in reset: idle values
    chk("rst_vde",  vde0, 0);
    chk("rst_ctl",  ctl0, 2'b11);
    chk("rst_pix",  {px0, py0}, 0);
    chk("rst_puls", {ls0, fs0}, 0);

    RSTN = 1'b1;
    @(negedge CLK);
    chk("first_vde", vde0, 1);
    chk("first_pix", {px0, py0}, 0);
    chk("first_fs",  fs0, 1);
    chk("first_ls",  ls0, 1);
    chk("first_ctl", ctl0, 2'b11);

    // One 640x480 line
    vcnt = 0; hcnt = 0; lcnt = 0; first = -1; last = -1;
    for (int i = 0; i < 800; i++) begin
      if (vde0) vcnt++;
      if (ls0) lcnt++;
      if (!hs0) begin
        hcnt++;
        if (first < 0) first = int'(px0);
        last = int'(px0);
      end
      @(negedge CLK);
    end
    chk("line_vde_cnt", vcnt, 640);
    chk("line_hs_cnt",  hcnt, 96);
    chk("line_hs_first", first, 656);
    chk("line_hs_last",  last, 751);
    chk("line_ls_cnt",  lcnt, 1);
    chk("line_ls_next", {ls0, px0, py0}, {1'b1, 12'd0, 12'd1});

    // One 1280x720 line, active-high HSYNC
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      if (ls2) found = 1'b1; else @(negedge CLK);
    end
    chk("tmo_ls2", found, 1);
    hcnt = 0; first = -1; last = -1;
    for (int i = 0; i < 1650; i++) begin
      if (hs2) begin
        hcnt++;
        if (first < 0) first = int'(px2);
        last = int'(px2);
      end
      @(negedge CLK);
    end
    chk("hd_hs_cnt",   hcnt, 40);
    chk("hd_hs_first", first, 1390);
    chk("hd_hs_last",  last, 1429);
    chk("hd_ls_period", {ls2, px2}, {1'b1, 12'd0});

    // Full frame on the tiny raster (16 x 9)
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (fs1) found = 1'b1; else @(negedge CLK);
    end
    chk("tmo_fs1", found, 1);
    fcnt = 0; vscnt = 0; vmin = 999; vmax = -1; badvde = 0; lpx = 0; lpy = 0;
    for (int i = 0; i < 144; i++) begin
      if (fs1) fcnt++;
      if (vs1) begin
        vscnt++;
        if (int'(py1) < vmin) vmin = int'(py1);
        if (int'(py1) > vmax) vmax = int'(py1);
      end
      if (vde1 && py1 >= 12'd4) badvde++;
      lpx = int'(px1); lpy = int'(py1);
      @(negedge CLK);
    end
    chk("fr_fs_cnt",  fcnt, 1);
    chk("fr_vs_cnt",  vscnt, 32);
    chk("fr_vs_min",  vmin, 5);
    chk("fr_vs_max",  vmax, 6);
    chk("fr_vde_blank", badvde, 0);
    chk("fr_last_pos", {12'(lpx), 12'(lpy)}, {12'd15, 12'd8});
    chk("fr_wrap", {fs1, px1, py1}, {1'b1, 12'd0, 12'd0});

    // EN gap mid-frame on the tiny raster
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (px1 == 12'd5 && py1 == 12'd2) found = 1'b1; else @(negedge CLK);
    end
    chk("tmo_en_pos", found, 1);
    en1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("en_gap", 32'(o1), 32'd0);
    end
    en1 = 1'b1;
    @(negedge CLK);
    chk("en_restart", {fs1, ls1, vde1, px1, py1}, {3'b111, 24'd0});

    // Asynchronous reset during HSYNC on the 640x480 raster
    found = 1'b0;
    for (int i = 0; i < 900 && !found; i++) begin
      if (px0 == 12'd700) found = 1'b1; else @(negedge CLK);
    end
    chk("tmo_px700", found, 1);
    chk("hs_active_700", hs0, 0);
    #2 RSTN = 1'b0;
    #1;
    chk("async_hs",  hs0, 1);
    chk("async_vde", vde0, 0);
    chk("async_pix", {px0, ctl0}, {12'd0, 2'b11});
    repeat (2) @(negedge CLK);
    RSTN = 1'b1;
    @(negedge CLK);
    chk("rst_restart", {fs0, vde0, px0, py0}, {2'b11, 24'd0});

    repeat (4) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Raster timing generator for the HDMI transmit path.
- Sits directly upstream of the three TMDS/DVI encoder lanes. It supplies the shared VDE strobe, the lane-0 control pair {VSYNC,HSYNC}, and the pixel coordinates the pixel source uses to fetch VIDDATA.
- Counts the pixel-clock raster (active, front porch, sync, back porch) horizontally and vertically. All outputs are registered.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, HSYNC asserted level (0 = active-low)
- V_POL, 0, VSYNC asserted level (0 = active-low)

Ports:
- CLK  input  1  pixel clock; all logic on posedge
- RSTN  input  1  asynchronous active-low reset
- EN  input  1  run enable; low = hold in blanking and restart frame
- VDE  output  1  video data enable to encoders
- HSYNC  output  1  horizontal sync, polarity per H_POL
- VSYNC  output  1  vertical sync, polarity per V_POL
- CONTROL  output  2  {VSYNC,HSYNC}, to lane-0 encoder CONTROL input
- PIX_X  output  12  horizontal counter value, aligned to VDE
- PIX_Y  output  12  vertical counter value, aligned to VDE
- LINE_START  output  1  one-cycle pulse at h=0 of every line
- FRAME_START  output  1  one-cycle pulse at h=0,v=0

Behaviour:
- One clock, CLK. Reset is asynchronous and active-low (RSTN); asserting it takes effect immediately, and release is sampled on CLK.
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525). Both must be ≤ 4096; the widths of the hCount, vCount, PIX_X and PIX_Y outputs are fixed at 12 bits.
- Internal counters hCount and vCount, each 12 bits unsigned.
  - hCount increments every cycle while EN=1 and wraps H_TOTAL-1 → 0.
  - vCount increments only when hCount wraps, and wraps V_TOTAL-1 → 0 on the same edge that hCount wraps from its last value.
- Regions, evaluated on counter value c with active region first:
  - active: c < ACTIVE
  - front porch: ACTIVE ≤ c < ACTIVE+FP
  - sync: ACTIVE+FP ≤ c < ACTIVE+FP+SYNC
  - back porch: remainder
- VSYNC asserts for all hCount while vCount is in the vertical sync region; it is line-aligned, not half-line offset.
- Output latency: every output is registered from the current counter values, so outputs lag the counters by 1 cycle. All outputs share this alignment.
  - VDE = (hCount<H_ACTIVE) && (vCount<V_ACTIVE).
  - HSYNC = H_POL when hCount is in the h-sync region, else ~H_POL.
  - VSYNC likewise with V_POL.
  - PIX_X = hCount and PIX_Y = vCount, unconditionally; they are also valid during blanking.
  - LINE_START = (hCount==0). FRAME_START = (hCount==0 && vCount==0).
- EN low:
  - On each clock edge, counters load 0.
  - Outputs register VDE=0, HSYNC=~H_POL, VSYNC=~V_POL, PIX_X=PIX_Y=0, and both pulses 0.
  - EN is sampled every cycle. Deasserting it mid-frame aborts the frame, with no completion of the current line.
  - Reasserting it starts at (0,0): outputs on the first edge with EN=1 show VDE=1, LINE_START=1, FRAME_START=1.
- Reset (RSTN=0) gives the same values as EN low: counters 0, VDE 0, syncs inactive, PIX 0, pulses 0, CONTROL={~V_POL,~H_POL}. Reset mid-frame is immediate.
- No other state; no handshake. Downstream consumers must accept one pixel per cycle while VDE=1.

Test Plan:
- Release RSTN with EN=1, defaults → first edge: VDE=1, PIX_X=0, PIX_Y=0, FRAME_START=1, LINE_START=1, HSYNC=1, VSYNC=1, CONTROL=2'b11. Before the edge, all outputs at reset values.
- Run one line → VDE high exactly 640 cycles (PIX_X 0..639). HSYNC=0 for exactly 96 cycles, starting at PIX_X=656 and ending after PIX_X=751. LINE_START period is 800 cycles.
- Run a full frame → FRAME_START period = 420000 cycles. VSYNC=0 for exactly 1600 cycles, with PIX_Y 490..491. VDE never high for PIX_Y ≥ 480. PIX_Y wraps 524 → 0 with PIX_X 799 → 0 on the same edge.
- Drop EN at PIX_X=300, PIX_Y=100 for 5 cycles, then raise it → VDE=0, syncs inactive, PIX=0 during the gap. The first edge after re-enable gives FRAME_START=1 at (0,0).
- Assert RSTN low asynchronously mid-line at PIX_X=700 (HSYNC active) → HSYNC returns to 1 and VDE to 0 without waiting for CLK. After release, restart at (0,0).
- Override H_POL=1, V_POL=1 with 1280x720 timings (110/40/220, 5/5/20) → H_TOTAL=1650, V_TOTAL=750. HSYNC high for 40 cycles at PIX_X 1390..1429. VSYNC high for lines 725..729.
